// File: rtl/quantize_pkg.sv
// quantize_pkg: shared FSM state type, default widths and
// saturation helpers for the quantize_pipe datapath.
package quantize_pkg;

    localparam int N_DEF  = 8;
    localparam int QW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } q_state_e;

    function automatic int sat_max(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int sat_min(input int n);
        return -(1 << (n - 1));
    endfunction

endpackage

// File: rtl/quantize_pipe_mag_div.sv
// mag_div: single-channel restoring divider, one quotient bit per step.
// Ports: clk, clear (async high), load_i/step_i control,
//        dvd_i (N+1-bit dividend), dvs_i (QW-bit divisor),
//        quot_nxt_o (quotient register next-state value).
module mag_div
    import quantize_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int QW = QW_DEF
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [N:0]    dvd_i,
    input  logic [QW-1:0] dvs_i,
    output logic [N:0]    quot_nxt_o
);

    logic [QW-1:0] rem_q, rem_d;
    logic [QW-1:0] dvs_q, dvs_d;
    logic [N:0]    quo_q, quo_d;
    logic [QW:0]   trial;
    logic          take;

    // The quotient register doubles as the dividend shifter: its MSB
    // feeds the remainder while quotient bits enter at the LSB.
    always_comb begin
        trial = {rem_q, quo_q[N]};
        take  = trial >= {1'b0, dvs_q};
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dvd_i;
            dvs_d = dvs_i;
        end else if (step_i) begin
            rem_d = take ? QW'(trial - {1'b0, dvs_q}) : trial[QW-1:0];
            quo_d = {quo_q[N-1:0], take};
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quot_nxt_o = quo_d;

endmodule

// File: rtl/quantize_pipe.sv
// quantize_pipe: complex-sample quantizer, z = sign(w)*(|w| / q) per channel.
// Ports: clk, clear (async high); in_valid/in_ready + w_r, w_im, q input
//        handshake; out_valid/out_ready + z_r, z_im, div_zero output.
// Build option: QUANTIZE_ROUND_EN selects round-half-up instead of truncate.
module quantize_pipe
    import quantize_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int QW = QW_DEF
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  w_r,
    input  logic [N-1:0]  w_im,
    input  logic [QW-1:0] q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  z_r,
    output logic [N-1:0]  z_im,
    output logic          div_zero
);

    localparam int CW = $clog2(N + 1);
    localparam int NW = N + 1;
    localparam logic [N-1:0] SMAX = N'(sat_max(N));
    localparam logic [N-1:0] SMIN = N'(sat_min(N));

    q_state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sr_q, sr_d, si_q, si_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  zr_q, zr_d, zi_q, zi_d;
    logic          dz_q, dz_d;
    logic          load, step;
    logic [N:0]    mag_r, mag_i, dvd_r, dvd_i;
    logic [N:0]    qn_r, qn_i;

    // N+1-bit magnitudes so that |-2^(N-1)| is representable.
    always_comb begin
        mag_r = w_r[N-1]  ? NW'(-{w_r[N-1], w_r})   : {1'b0, w_r};
        mag_i = w_im[N-1] ? NW'(-{w_im[N-1], w_im}) : {1'b0, w_im};
`ifdef QUANTIZE_ROUND_EN
        dvd_r = mag_r + NW'(q >> 1);
        dvd_i = mag_i + NW'(q >> 1);
`else
        dvd_r = mag_r;
        dvd_i = mag_i;
`endif
    end

    mag_div #(.N(N), .QW(QW)) u_div_r (
        .clk        (clk),
        .clear      (clear),
        .load_i     (load),
        .step_i     (step),
        .dvd_i      (dvd_r),
        .dvs_i      (q),
        .quot_nxt_o (qn_r)
    );

    mag_div #(.N(N), .QW(QW)) u_div_i (
        .clk        (clk),
        .clear      (clear),
        .load_i     (load),
        .step_i     (step),
        .dvd_i      (dvd_i),
        .dvs_i      (q),
        .quot_nxt_o (qn_i)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        si_d    = si_q;
        zero_d  = zero_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        dz_d    = dz_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    sr_d    = w_r[N-1];
                    si_d    = w_im[N-1];
                    zero_d  = (q == '0);
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                // A zero divisor spends one DIV cycle so its result
                // appears one cycle after accept.
                if (zero_q) begin
                    zr_d    = sr_q ? SMIN : SMAX;
                    zi_d    = si_q ? SMIN : SMAX;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N)) begin
                        cnt_d   = '0;
                        zr_d    = N'(sr_q ? -qn_r : qn_r);
                        zi_d    = N'(si_q ? -qn_i : qn_i);
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= 1'b0;
            si_q    <= 1'b0;
            zero_q  <= 1'b0;
            zr_q    <= '0;
            zi_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            si_q    <= si_d;
            zero_q  <= zero_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !clear;
    assign out_valid = (state_q == DONE);
    assign z_r       = zr_q;
    assign z_im      = zi_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_quantize_pipe.sv
// tb_quantize_pipe: directed vector table plus handshake, reset and
// back-to-back sequences for quantize_pipe (N=8, QW=8).
module tb_quantize_pipe;

    logic       clk = 1'b0;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] w_r, w_im, q;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] z_r, z_im;
    logic       div_zero;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    quantize_pipe #(.N(8), .QW(8)) dut (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w_r       (w_r),
        .w_im      (w_im),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_r       (z_r),
        .z_im      (z_im),
        .div_zero  (div_zero)
    );

    typedef struct {
        int wr;
        int wi;
        int qv;
        int er;
        int ei;
        int edz;
        int elat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_txn(input int wr, input int wi, input int qv,
                          output int zr, output int zi,
                          output int dz, output int lat);
        int n;
        w_r      = 8'(wr);
        w_im     = 8'(wi);
        q        = 8'(qv);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 50);
        zr = int'($signed(z_r));
        zi = int'($signed(z_im));
        dz = int'(div_zero);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("idle_after_handshake", int'(in_ready), 1);
    endtask

    int zr, zi, dz, lat, n;
    int acc[4];
    int sr[4], si[4], sq[4], ser[4], sei[4];
    int k, outk;
    logic acc_now;

    initial begin
`ifdef QUANTIZE_ROUND_EN
        vecs[0] = '{-7,   20,   3,   -2,   7,    0, 9};
        vecs[5] = '{-1,   50,   2,   -1,   25,   0, 9};
        vecs[7] = '{127,  -128, 128, 1,    -1,   0, 9};
        sr[0] = 10;  si[0] = -10;  sq[0] = 3; ser[0] = 3;   sei[0] = -3;
        sr[2] = -50; si[2] = 25;   sq[2] = 5; ser[2] = -10; sei[2] = 5;
`else
        vecs[0] = '{-7,   20,   3,   -2,   6,    0, 9};
        vecs[5] = '{-1,   50,   2,   0,    25,   0, 9};
        vecs[7] = '{127,  -128, 128, 0,    -1,   0, 9};
        sr[0] = 10;  si[0] = -10;  sq[0] = 3; ser[0] = 3;   sei[0] = -3;
        sr[2] = -50; si[2] = 25;   sq[2] = 5; ser[2] = -10; sei[2] = 5;
`endif
        vecs[1] = '{-128, 127,  1,   -128, 127,  0, 9};
        vecs[2] = '{5,    -1,   0,   127,  -128, 1, 1};
        vecs[3] = '{100,  -100, 7,   14,   -14,  0, 9};
        vecs[4] = '{0,    1,    255, 0,    0,    0, 9};
        vecs[6] = '{0,    -128, 0,   127,  -128, 1, 1};
        vecs[8] = '{-5,   13,   4,   -1,   3,    0, 9};
        sr[1] = 64; si[1] = -64;  sq[1] = 8; ser[1] = 8; sei[1] = -8;
        sr[3] = -1; si[3] = -128; sq[3] = 9; ser[3] = 0; sei[3] = -14;

        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        w_r = '0; w_im = '0; q = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_z_r", int'(z_r), 0);
        chk("rst_z_im", int'(z_im), 0);
        chk("rst_div_zero", int'(div_zero), 0);
        clear = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].wr, vecs[i].wi, vecs[i].qv, zr, zi, dz, lat);
            chk($sformatf("v%0d_z_r", i), zr, vecs[i].er);
            chk($sformatf("v%0d_z_im", i), zi, vecs[i].ei);
            chk($sformatf("v%0d_div_zero", i), dz, vecs[i].edz);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].elat);
        end

        // backpressure: result held 5 cycles, new request ignored
        w_r = 8'hF9; w_im = 8'd20; q = 8'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bp_valid_seen", int'(out_valid), 1);
        w_r = 8'd1; w_im = 8'd1; q = 8'd1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_z_r", int'($signed(z_r)), -2);
            chk("bp_z_im", int'($signed(z_im)), vecs[0].ei);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_in_ready_after", int'(in_ready), 1);
        chk("bp_out_valid_after", int'(out_valid), 0);
        repeat (3) @(negedge clk);
        chk("bp_no_ghost", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // clear during the 4th DIV iteration
        w_r = 8'd50; w_im = 8'd60; q = 8'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        #1;
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_in_ready", int'(in_ready), 0);
        chk("mid_z_r", int'(z_r), 0);
        chk("mid_z_im", int'(z_im), 0);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk);
        #1;
        do_txn(100, 0, 7, zr, zi, dz, lat);
        chk("post_clr_z_r", zr, 14);
        chk("post_clr_z_im", zi, 0);
        chk("post_clr_lat", lat, 9);

        // back-to-back with in_valid and out_ready held high
        k = 0; outk = 0;
        w_r = 8'(sr[0]); w_im = 8'(si[0]); q = 8'(sq[0]);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (outk < 4) begin
                    chk($sformatf("b2b%0d_z_r", outk), int'($signed(z_r)), ser[outk]);
                    chk($sformatf("b2b%0d_z_im", outk), int'($signed(z_im)), sei[outk]);
                    chk($sformatf("b2b%0d_dz", outk), int'(div_zero), 0);
                end
                outk++;
            end
            acc_now = in_ready && in_valid;
            if (acc_now) acc[k] = cyc;
            @(posedge clk);
            #1;
            if (acc_now) begin
                k++;
                if (k < 4) begin
                    w_r = 8'(sr[k]); w_im = 8'(si[k]); q = 8'(sq[k]);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        chk("b2b_accepts", k, 4);
        chk("b2b_outputs", outk, 4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("b2b_ii%0d", i), acc[i] - acc[i-1], 11);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
